div_seq_ctrl: RTL
=================

Name: div_seq_ctrl

Overview:
- Sequential unsigned divider controller for the calculator datapath.
- Computes quotient and remainder by driving one shared subtract/compare step per clock, restoring algorithm, bits iterations.
- Sits between the operation decoder (start, operands) and the result mux / error display (quotient, remainder, div_err).
- Handshake is start/busy/done.

Parameters:
- bits, 8, operand and result width; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  bits  numerator; sampled with start.
- divisor  input  bits  denominator; sampled with start.
- busy  output  1  high while iterating (RUN state).
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  bits  result; held until next accepted start.
- remainder  output  bits  result; held until next accepted start.
- div_err  output  1  divide-by-zero flag; held with results.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - State IDLE; busy=0, done=0, div_err=0.
  - quotient=0, remainder=0.
  - Internal registers cleared.
- Reset asserted mid-operation aborts immediately. No done is produced for the aborted request.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with divisor≠0: latch operands, rem_acc=0, q_acc=dividend, cnt=bits-1, go RUN.
  - start=1 with divisor=0: go DONE directly; latch quotient = all ones, remainder = dividend, div_err=1.
  - start=0: stay IDLE.
- RUN, one step per cycle:
  - t = {rem_acc[bits-1:0], q_acc[bits-1]}, bits+1 wide.
  - If t >= {1'b0,divisor}: rem_acc = t - divisor, shifted-in q bit = 1.
  - Otherwise: rem_acc = t[bits-1:0], q bit = 0.
  - q_acc shifts left, new bit into LSB.
  - When cnt==0: go DONE, load quotient/remainder from the final step and clear div_err. Otherwise cnt decrements.
- DONE: done=1 for exactly this cycle, then go IDLE.
- Latency:
  - Start accepted at edge E0; busy=1 for bits cycles; done=1 in the cycle after edge E(bits).
  - Total: bits+1 cycles from start to the done cycle.
  - Divide-by-zero: done in the cycle after E0 (1 cycle).
- start while RUN or DONE is ignored. It is not queued; the requester must wait for done.
- start asserted in the DONE cycle is ignored. It is accepted one cycle later, in IDLE.
- Outputs quotient/remainder/div_err change only on entry to DONE.
- Compare width is bits+1, so there is no overflow at the maximum dividend or divisor.

Optional Feature:
- Macro: DIV_SEQ_EARLY_EXIT_EN.
- Defined:
  - In IDLE, if dividend < divisor (divisor≠0), go straight to DONE with quotient=0, remainder=dividend, div_err=0.
  - done then appears in the cycle after E0 and busy never asserts.
  - All other cases are unchanged.
- Undefined: every nonzero-divisor request takes the full bits iterations.

Decomposition:
- Shared package calc_pkg:
  - State encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default width constant: CALC_BITS=8.
  - Divide-by-zero quotient fill constant: all ones.
- Sub-module div_step (combinational, parameter bits):
  - Inputs: rem_in, msb_in, divisor.
  - Outputs: rem_out, q_bit.
  - Contains the bits+1 subtract/compare.
  - Instantiated once and shared across all iterations.

Test Plan:
1. Reset held, then released; start=0 -> busy=0, done=0, quotient=0, remainder=0, div_err=0.
2. bits=8, dividend=200, divisor=7, start 1 cycle -> busy high 8 cycles; done at cycle 9; quotient=28, remainder=4, div_err=0.
3. dividend=255, divisor=1 -> quotient=255, remainder=0. Then back-to-back with 255/255 -> quotient=1, remainder=0.
4. dividend=37, divisor=0 -> done in the next cycle; quotient=8'hFF, remainder=37, div_err=1, busy never high.
5. 5/9:
   - Without the macro: 9-cycle latency, quotient=0, remainder=5.
   - With DIV_SEQ_EARLY_EXIT_EN: 1-cycle latency, same results.
6. Abort and ignore:
   - start 100/3, pulse start again at RUN cycle 3 -> ignored, results 33 r1.
   - Repeat the request and drop rst_n at RUN cycle 4 -> outputs clear asynchronously, no done pulse.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator datapath blocks.
//   - div_state_t : divider controller state encoding (IDLE/RUN/DONE)
//   - CALC_BITS   : default operand/result width
//   - DIV_ZERO_FILL : quotient pattern reported on divide-by-zero (all ones,
//                     sliced down to the instance width)
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  localparam int CALC_BITS = 8;

  localparam logic [31:0] DIV_ZERO_FILL = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (combinational).
// Ports:
//   rem_in  [bits]  partial remainder entering this step (always < divisor)
//   msb_in  [1]     next dividend bit shifted into the remainder
//   divisor [bits]  denominator (nonzero while in use)
//   rem_out [bits]  partial remainder after the trial subtract
//   q_bit   [1]     quotient bit produced by this step
module div_step #(
  parameter int bits = 8
) (
  input  logic [bits-1:0] rem_in,
  input  logic            msb_in,
  input  logic [bits-1:0] divisor,
  output logic [bits-1:0] rem_out,
  output logic            q_bit
);

  logic [bits:0] t;
  logic          ge;

  // The shifted remainder needs bits+1 to compare without overflow. When
  // t >= divisor the true difference is below divisor, so the low bits of
  // the subtraction are exact and the carry bit can be dropped.
  always_comb begin
    t       = {rem_in, msb_in};
    ge      = (t >= {1'b0, divisor});
    q_bit   = ge;
    rem_out = ge ? (t[bits-1:0] - divisor) : t[bits-1:0];
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequential unsigned restoring divider, one step per clock.
// Build option: DIV_SEQ_EARLY_EXIT_EN - when defined, a request with
//   dividend < divisor (divisor nonzero) finishes directly without iterating.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 request, only sampled in IDLE
//   dividend, divisor     operands, sampled with an accepted start
//   busy                  high while iterating (RUN)
//   done                  one-cycle pulse when results become valid
//   quotient, remainder   results, held until the next accepted start
//   div_err               divide-by-zero flag, held with the results
//   dbg_state             current FSM state
// Handshake: start is taken on a rising edge only while IDLE; the requester
// waits for the done pulse before issuing another start. start in RUN or
// DONE is dropped, not queued.
module div_seq_ctrl
  import calc_pkg::*;
#(
  parameter int bits = CALC_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [bits-1:0] dividend,
  input  logic [bits-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [bits-1:0] quotient,
  output logic [bits-1:0] remainder,
  output logic            div_err,
  output div_state_t      dbg_state
);

  localparam int CW = (bits > 1) ? $clog2(bits) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(bits - 1);

  div_state_t      state;
  logic [bits-1:0] div_reg;
  logic [bits-1:0] rem_acc;
  logic [bits-1:0] q_acc;
  logic [CW-1:0]   cnt;

  logic [bits-1:0] step_rem;
  logic            step_q;
  logic [bits-1:0] q_next;

  // Single shared step; q_acc holds the unconsumed dividend bits in its top
  // and the accumulated quotient bits in its bottom.
  div_step #(.bits(bits)) u_step (
    .rem_in  (rem_acc),
    .msb_in  (q_acc[bits-1]),
    .divisor (div_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign q_next    = {q_acc[bits-2:0], step_q};
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      div_reg   <= '0;
      rem_acc   <= '0;
      q_acc     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              quotient  <= DIV_ZERO_FILL[bits-1:0];
              remainder <= dividend;
              div_err   <= 1'b1;
              done      <= 1'b1;
              state     <= ST_DONE;
            end
`ifdef DIV_SEQ_EARLY_EXIT_EN
            else if (dividend < divisor) begin
              quotient  <= '0;
              remainder <= dividend;
              div_err   <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end
`endif
            else begin
              div_reg <= divisor;
              rem_acc <= '0;
              q_acc   <= dividend;
              cnt     <= CNT_INIT;
              busy    <= 1'b1;
              state   <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          rem_acc <= step_rem;
          q_acc   <= q_next;
          if (cnt == '0) begin
            quotient  <= q_next;
            remainder <= step_rem;
            div_err   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
